// File: rtl/fp_exec_ctrl.sv
// FP execute sequencer: holds op/format for a fixed latency, then one RF write.
// Optional FP_EXEC_CTRL_EARLY_READY_EN lets a new op be accepted during WB.
module fp_exec_ctrl #(
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 4,
    parameter int LAT_DIV  = 12,
    parameter int LAT_SQRT = 16,
    parameter int LAT_MISC = 1
) (
    input  logic       Clk,
    input  logic       in_Rst_n,
    input  logic       in_issue_valid,
    output logic       out_issue_ready,
    input  logic [3:0] in_issue_op,
    input  logic       in_issue_fmt,
    input  logic [4:0] in_issue_rd,
    input  logic       in_flush,
    input  logic       in_wb_stall,
    input  logic [4:0] in_chk_rs1,
    input  logic [4:0] in_chk_rs2,
    input  logic [4:0] in_chk_rd,
    output logic [3:0] out_FPU_Op,
    output logic       out_fmt,
    output logic       out_wr_en,
    output logic [4:0] out_wr_addr,
    output logic       out_busy,
    output logic       out_hazard,
    output logic       out_illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0] state;
    logic [4:0] cnt;
    logic [3:0] op_q;
    logic       fmt_q;
    logic [4:0] rd_q;
    logic       illegal_q;

    logic       wr_go;
    logic       accept;
    logic       legal;
    logic [4:0] lat_m1;

    assign wr_go = (state == S_WB) & ~in_wb_stall & ~in_flush;

`ifdef FP_EXEC_CTRL_EARLY_READY_EN
    assign out_issue_ready = (state == S_IDLE) | wr_go;
`else
    assign out_issue_ready = (state == S_IDLE);
`endif

    // A flush always wins over a same-cycle issue, even while idle.
    assign accept = in_issue_valid & out_issue_ready & ~in_flush;
    assign legal  = ~in_issue_op[3];

    always_comb begin
        lat_m1 = 5'(LAT_MISC - 1);
        case (in_issue_op)
            4'd0, 4'd1: lat_m1 = 5'(LAT_ADD - 1);
            4'd2:       lat_m1 = 5'(LAT_MUL - 1);
            4'd3:       lat_m1 = 5'(LAT_DIV - 1);
            4'd4:       lat_m1 = 5'(LAT_SQRT - 1);
            default:    lat_m1 = 5'(LAT_MISC - 1);
        endcase
    end

    always_ff @(posedge Clk or negedge in_Rst_n) begin
        if (!in_Rst_n) begin
            state     <= S_IDLE;
            cnt       <= 5'd0;
            op_q      <= 4'd0;
            fmt_q     <= 1'b0;
            rd_q      <= 5'd0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept & ~legal;
            if (accept & legal) begin
                state <= S_EXEC;
                cnt   <= lat_m1;
                op_q  <= in_issue_op;
                fmt_q <= in_issue_fmt;
                rd_q  <= in_issue_rd;
            end else if (in_flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: state <= S_IDLE;
                    S_EXEC: begin
                        if (cnt == 5'd0) state <= S_WB;
                        else             cnt   <= cnt - 5'd1;
                    end
                    S_WB: begin
                        if (!in_wb_stall) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign out_FPU_Op  = op_q;
    assign out_fmt     = fmt_q;
    assign out_wr_en   = wr_go;
    assign out_wr_addr = rd_q;
    assign out_busy    = (state != S_IDLE);
    assign out_illegal = illegal_q;
    assign out_hazard  = out_busy & ((in_chk_rs1 == rd_q) |
                                     (in_chk_rs2 == rd_q) |
                                     (in_chk_rd  == rd_q));

endmodule

// File: tb/tb_fp_exec_ctrl.sv
// Directed bench for fp_exec_ctrl: latency, stall, hazard, flush, illegal, reset.
module tb_fp_exec_ctrl;

    logic       Clk = 1'b0;
    logic       in_Rst_n;
    logic       in_issue_valid;
    logic       out_issue_ready;
    logic [3:0] in_issue_op;
    logic       in_issue_fmt;
    logic [4:0] in_issue_rd;
    logic       in_flush;
    logic       in_wb_stall;
    logic [4:0] in_chk_rs1;
    logic [4:0] in_chk_rs2;
    logic [4:0] in_chk_rd;
    logic [3:0] out_FPU_Op;
    logic       out_fmt;
    logic       out_wr_en;
    logic [4:0] out_wr_addr;
    logic       out_busy;
    logic       out_hazard;
    logic       out_illegal;

    int total = 0;
    int bad   = 0;
    int nwr;
    int w1;
    int w2;
    int spacing;

    fp_exec_ctrl dut (
        .Clk            (Clk),
        .in_Rst_n       (in_Rst_n),
        .in_issue_valid (in_issue_valid),
        .out_issue_ready(out_issue_ready),
        .in_issue_op    (in_issue_op),
        .in_issue_fmt   (in_issue_fmt),
        .in_issue_rd    (in_issue_rd),
        .in_flush       (in_flush),
        .in_wb_stall    (in_wb_stall),
        .in_chk_rs1     (in_chk_rs1),
        .in_chk_rs2     (in_chk_rs2),
        .in_chk_rd      (in_chk_rd),
        .out_FPU_Op     (out_FPU_Op),
        .out_fmt        (out_fmt),
        .out_wr_en      (out_wr_en),
        .out_wr_addr    (out_wr_addr),
        .out_busy       (out_busy),
        .out_hazard     (out_hazard),
        .out_illegal    (out_illegal)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        in_Rst_n       = 1'b0;
        in_issue_valid = 1'b0;
        in_issue_op    = 4'd0;
        in_issue_fmt   = 1'b0;
        in_issue_rd    = 5'd0;
        in_flush       = 1'b0;
        in_wb_stall    = 1'b0;
        in_chk_rs1     = 5'd31;
        in_chk_rs2     = 5'd31;
        in_chk_rd      = 5'd31;

        // reset values
        #12;
        chk("rst_ready", 32'(out_issue_ready), 32'd1);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_wr_en", 32'(out_wr_en), 32'd0);
        chk("rst_op", 32'(out_FPU_Op), 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        @(negedge Clk);
        in_Rst_n = 1'b1;
        tick();

        // FMUL rd=7 double, latency 4
        in_issue_valid = 1'b1;
        in_issue_op    = 4'd2;
        in_issue_fmt   = 1'b1;
        in_issue_rd    = 5'd7;
        #1;
        chk("mul_ready", 32'(out_issue_ready), 32'd1);
        tick();
        in_issue_valid = 1'b0;
        #1;
        chk("mul_busy", 32'(out_busy), 32'd1);
        chk("mul_fmt", 32'(out_fmt), 32'd1);
        chk("mul_wr0", 32'(out_wr_en), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("mul_wr", 32'(out_wr_en), 32'(k == 4));
            chk("mul_op", 32'(out_FPU_Op), 32'd2);
            if (k == 4) chk("mul_addr", 32'(out_wr_addr), 32'd7);
        end
        tick();
        chk("mul_after_wr", 32'(out_wr_en), 32'd0);
        chk("mul_after_busy", 32'(out_busy), 32'd0);
        chk("mul_op_held", 32'(out_FPU_Op), 32'd2);

        // FSQRT with 3 stalled WB cycles
        in_issue_valid = 1'b1;
        in_issue_op    = 4'd4;
        in_issue_fmt   = 1'b0;
        in_issue_rd    = 5'd3;
        in_wb_stall    = 1'b1;
        tick();
        in_issue_valid = 1'b0;
        nwr = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk);
            #1;
            if (k == 19) in_wb_stall = 1'b0;
            #1;
            if (out_wr_en) nwr++;
            chk("sqrt_wr", 32'(out_wr_en), 32'(k == 19));
            chk("sqrt_busy", 32'(out_busy), 32'(k <= 19));
        end
        chk("sqrt_nwr", 32'(nwr), 32'd1);

        // hazard on FDIV rd=5
        in_chk_rs2 = 5'd5;
        #1;
        chk("haz_idle", 32'(out_hazard), 32'd0);
        in_issue_valid = 1'b1;
        in_issue_op    = 4'd3;
        in_issue_rd    = 5'd5;
        tick();
        in_issue_valid = 1'b0;
        #1;
        chk("haz_hit", 32'(out_hazard), 32'd1);
        in_chk_rs2 = 5'd6;
        #1;
        chk("haz_miss", 32'(out_hazard), 32'd0);
        in_chk_rs2 = 5'd5;
        for (int k = 1; k <= 12; k++) tick();
        chk("div_wr", 32'(out_wr_en), 32'd1);
        chk("div_addr", 32'(out_wr_addr), 32'd5);
        chk("haz_wb", 32'(out_hazard), 32'd1);
        tick();
        chk("haz_done", 32'(out_hazard), 32'd0);
        in_chk_rs2 = 5'd31;

        // flush during EXEC of FADD
        in_issue_valid = 1'b1;
        in_issue_op    = 4'd0;
        in_issue_rd    = 5'd9;
        tick();
        in_issue_valid = 1'b0;
        tick();
        in_flush = 1'b1;
        #1;
        chk("flush_ready_exec", 32'(out_issue_ready), 32'd0);
        tick();
        in_flush = 1'b0;
        #1;
        chk("flush_busy", 32'(out_busy), 32'd0);
        chk("flush_ready", 32'(out_issue_ready), 32'd1);
        nwr = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_wr_en) nwr++;
        end
        chk("flush_nowr", 32'(nwr), 32'd0);

        // flush suppresses an issue while idle
        in_issue_valid = 1'b1;
        in_flush       = 1'b1;
        #1;
        chk("flush_idle_ready", 32'(out_issue_ready), 32'd1);
        tick();
        in_issue_valid = 1'b0;
        in_flush       = 1'b0;
        #1;
        chk("flush_idle_busy", 32'(out_busy), 32'd0);

        // flush during WB kills the write
        in_issue_valid = 1'b1;
        in_issue_op    = 4'd7;
        in_issue_rd    = 5'd1;
        tick();
        in_issue_valid = 1'b0;
        tick();
        in_flush = 1'b1;
        #1;
        chk("flush_wb_wr", 32'(out_wr_en), 32'd0);
        tick();
        in_flush = 1'b0;
        #1;
        chk("flush_wb_busy", 32'(out_busy), 32'd0);

        // illegal op 9
        in_issue_valid = 1'b1;
        in_issue_op    = 4'd9;
        tick();
        in_issue_valid = 1'b0;
        #1;
        chk("ill_pulse", 32'(out_illegal), 32'd1);
        chk("ill_busy", 32'(out_busy), 32'd0);
        tick();
        chk("ill_clear", 32'(out_illegal), 32'd0);

        // back-to-back FMIN ops
        in_issue_valid = 1'b1;
        in_issue_op    = 4'd5;
        in_issue_rd    = 5'd2;
        nwr = 0;
        w1  = 0;
        w2  = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (out_wr_en) begin
                nwr++;
                if (nwr == 1) w1 = k;
                else if (nwr == 2) w2 = k;
            end
        end
        in_issue_valid = 1'b0;
`ifdef FP_EXEC_CTRL_EARLY_READY_EN
        spacing = 2;
`else
        spacing = 3;
`endif
        chk("b2b_first", 32'(w1), 32'd2);
        chk("b2b_spacing", 32'(w2 - w1), 32'(spacing));
        for (int k = 0; k < 6; k++) tick();
        chk("b2b_idle", 32'(out_busy), 32'd0);

        // reset mid-FDIV
        in_issue_valid = 1'b1;
        in_issue_op    = 4'd3;
        in_issue_fmt   = 1'b1;
        in_issue_rd    = 5'd10;
        tick();
        in_issue_valid = 1'b0;
        in_chk_rs1     = 5'd10;
        tick();
        tick();
        chk("div_hazard", 32'(out_hazard), 32'd1);
        #2;
        in_Rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(out_busy), 32'd0);
        chk("mid_rst_ready", 32'(out_issue_ready), 32'd1);
        chk("mid_rst_op", 32'(out_FPU_Op), 32'd0);
        chk("mid_rst_fmt", 32'(out_fmt), 32'd0);
        chk("mid_rst_addr", 32'(out_wr_addr), 32'd0);
        chk("mid_rst_hazard", 32'(out_hazard), 32'd0);
        @(negedge Clk);
        in_Rst_n = 1'b1;
        nwr = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (out_wr_en) nwr++;
        end
        chk("mid_rst_nowr", 32'(nwr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_exec_ctrl.md
# fp_exec_ctrl

Sequencer for the floating-point execute path. It accepts one FP operation at a time from the main control unit and holds the FPU opcode and format steady for the operation's fixed latency. It then issues a single write into the FP register file, stalling while the write port is busy. It also exposes a one-entry scoreboard so the control unit can stall dependent instructions. It sits between the control unit and the FP_Unit / FP_RegisterFile pair inside the datapath.

## Interface
Parameters:
- LAT_ADD, 3, cycles for FADD/FSUB
- LAT_MUL, 4, cycles for FMUL
- LAT_DIV, 12, cycles for FDIV
- LAT_SQRT, 16, cycles for FSQRT
- LAT_MISC, 1, cycles for FMIN/FMAX/FSGNJ

All LAT_* values are ≥1 and ≤31.

Ports:
- Clk  in  1  clock, rising edge
- in_Rst_n  in  1  asynchronous active-low reset
- in_issue_valid  in  1  issue request
- out_issue_ready  out  1  controller can accept
- in_issue_op  in  4  op: 0 FADD, 1 FSUB, 2 FMUL, 3 FDIV, 4 FSQRT, 5 FMIN, 6 FMAX, 7 FSGNJ, 8–15 illegal
- in_issue_fmt  in  1  0 single, 1 double
- in_issue_rd  in  5  destination FP register
- in_flush  in  1  abort in-flight op, no write
- in_wb_stall  in  1  FP RF write port taken this cycle
- in_chk_rs1, in_chk_rs2, in_chk_rd  in  5 each  registers of the instruction being decoded
- out_FPU_Op  out  4  held opcode to FP_Unit
- out_fmt  out  1  held format to FP_Unit
- out_wr_en  out  1  FP RF write enable
- out_wr_addr  out  5  FP RF write address
- out_busy  out  1  op in flight (EXEC or WB)
- out_hazard  out  1  combinational dependency flag
- out_illegal  out  1  one-cycle pulse on rejected op

## Operation
- States: IDLE, EXEC, WB. A 5-bit down-counter cnt, plus registered op, fmt and rd.
- IDLE: out_issue_ready=1. On valid&ready with a legal op:
  - latch op, fmt and rd;
  - load cnt = LAT(op)−1;
  - go to EXEC.
- Illegal op on valid&ready: accepted, no state change, out_illegal=1 the next cycle.
- EXEC: out_issue_ready=0.
  - cnt≠0: decrement.
  - cnt=0: go to WB.
- WB: out_wr_en = ~in_wb_stall, out_wr_addr = latched rd.
  - in_wb_stall=1: remain in WB.
  - in_wb_stall=0: go to IDLE, unless an early issue is accepted (see Configuration), in which case go to EXEC.
- out_FPU_Op and out_fmt hold the latched values in EXEC and WB. In IDLE they keep their last value; they are not cleared.
- out_busy = (state≠IDLE).
- out_hazard = out_busy & (in_chk_rs1==rd | in_chk_rs2==rd | in_chk_rd==rd). Register 0 is not special: FP registers are all writable.
- in_flush has highest priority in EXEC/WB:
  - next state IDLE;
  - out_wr_en forced 0 that cycle;
  - a simultaneous issue in IDLE is ignored (ready is still shown, but the accept is suppressed).

## Timing
- Reset (async assert, sync release): state IDLE, cnt=0, out_issue_ready=1, out_FPU_Op=0, out_fmt=0, out_wr_en=0, out_wr_addr=0, out_busy=0, out_hazard=0, out_illegal=0.
- Accept at edge E0 → EXEC from E0. WB is entered at edge E0+LAT. out_wr_en is high in the cycle following edge E0+LAT, assuming no stall.
- Each stalled cycle adds one cycle. The write happens exactly once per legal, unflushed op.
- Throughput without early ready: one op per LAT+2 cycles (LAT EXEC, one WB, one IDLE).
- Reset asserted mid-operation: immediate return to reset values; no write is issued.

## Configuration
- FP_EXEC_CTRL_EARLY_READY_EN defined: out_issue_ready is also 1 in WB when in_wb_stall=0 and in_flush=0. An accept at that edge performs the current write and loads the new op into EXEC in the same edge. Back-to-back throughput becomes LAT+1.
  - out_hazard still compares against the current rd until that edge. The control unit is responsible for the write-then-read order.
- Not defined: out_issue_ready=1 only in IDLE.

## Test plan
- Reset: drive in_Rst_n low mid-FDIV → all outputs at reset values immediately; no out_wr_en after release.
- FMUL, rd=7, fmt=1, accepted at E0, no stall → out_wr_en=1 and out_wr_addr=7 only in the cycle after E0+4; out_FPU_Op=2 and out_fmt=1 throughout.
- FSQRT with in_wb_stall held high for 3 WB cycles → exactly one out_wr_en pulse, 3 cycles later than the no-stall case; out_busy stays high until the write.
- Hazard: FDIV to rd=5 in flight, in_chk_rs2=5 → out_hazard=1; in_chk_rs2=6 → 0; after the write, out_hazard=0.
- in_flush during EXEC of FADD → IDLE next cycle, no write, out_issue_ready=1.
- Illegal op 9 → out_illegal pulses once, state stays IDLE. With FP_EXEC_CTRL_EARLY_READY_EN, two FMISC ops issued back to back → writes 2 cycles apart.
